uart_cmd_ctrl: RTL and testbench

Frame parser and output sequencer between the UART receiver and the drive outputs (D, Adress, Mod_SEL, TRP, led) of TOP. It consumes received bytes and assembles fixed 8-byte command frames. It validates header, checksum and tail, then applies the payload atomically to the output registers, optionally firing a TRP pulse. Every completed frame gets an ACK or NAK byte, returned through the UART transmitter handshake.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/uart_cmd_ctrl_if.sv | 23 ++
 rtl/uart_cmd_ctrl_trp_pulse.sv | 35 +++
 rtl/uart_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command-frame controller: parser state
// encoding, frame marker / response byte values and CTRL field positions.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOD,
        ST_D2,
        ST_D1,
        ST_D0,
        ST_CTRL,
        ST_CHK,
        ST_TAIL
    } parser_state_t;

    localparam logic [7:0] HDR  = 8'hFF;
    localparam logic [7:0] TAIL = 8'h0A;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    localparam int unsigned CTRL_TRP_BIT = 7;
    localparam int unsigned CTRL_ADR_HI  = 1;
    localparam int unsigned CTRL_ADR_LO  = 0;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Byte-level handshake between the UART receiver/transmitter and the
// command controller.
//   rx_done  : one-cycle strobe, rx_data valid
//   rx_data  : received byte
//   tx_busy  : transmitter busy, do not start a new byte
//   tx_en    : one-cycle start strobe to the transmitter
//   tx_data  : response byte, stable from the tx_en cycle onward
// master = UART side, slave = command controller side.
// ---------------------------------------------------------------------------
interface uart_cmd_ctrl_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;

    modport master (output rx_done, output rx_data, output tx_busy,
                    input  tx_en,   input  tx_data);
    modport slave  (input  rx_done, input  rx_data, input  tx_busy,
                    output tx_en,   output tx_data);
endinterface

// File: rtl/uart_cmd_ctrl_trp_pulse.sv
// ---------------------------------------------------------------------------
// trp_pulse
// Restartable pulse stretcher: pulse is high for TRP_WIDTH cycles after the
// last trig; a trig during an active pulse reloads the count.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   trig  : one-cycle trigger request
//   pulse : stretched output pulse
// ---------------------------------------------------------------------------
module trp_pulse #(
    parameter int unsigned TRP_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic pulse
);

    localparam int unsigned CW = $clog2(TRP_WIDTH + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (trig) begin
            r_cnt <= CW'(TRP_WIDTH);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign pulse = (r_cnt != '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses 8-byte command frames (FF MOD D2 D1 D0 CTRL CHK 0A) from the UART
// receiver, applies validated payloads atomically to the drive outputs,
// fires the TRP pulse on request and queues an ACK/NAK response byte.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : UART rx/tx handshake (slave side)
//   D         : 24-bit data word
//   Adress    : channel address
//   Mod_SEL   : mode select
//   TRP       : trigger pulse
//   led       : toggles on every good frame
//   frame_err : one-cycle strobe on NAK or inter-byte timeout
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned UART_BPS      = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter int unsigned TRP_WIDTH     = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    uart_cmd_ctrl_if.slave        bus,
    output logic [23:0]           D,
    output logic [1:0]            Adress,
    output logic [5:0]            Mod_SEL,
    output logic                  TRP,
    output logic                  led,
    output logic                  frame_err
);

    // Idle gap allowed inside a frame, in sys_clk cycles.
    localparam longint unsigned TO_CALC =
        longint'(TIMEOUT_BYTES) * 10 * longint'(CLK_FREQ) / longint'(UART_BPS);
    localparam int unsigned TO_LIMIT = 32'(TO_CALC);
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    parser_state_t r_state, w_state_nxt;

    logic [7:0]      r_mod, r_d2, r_d1, r_d0, r_ctrl, r_chk;
    logic [7:0]      w_sum;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_term;
    logic            w_good, w_bad, w_timeout, w_trig;

    logic [23:0]     r_d_out;
    logic [1:0]      r_adr;
    logic [5:0]      r_mod_sel;
    logic            r_led, r_ferr;
    logic            r_pend, r_tx_en;
    logic [7:0]      r_resp, r_tx_data;

    assign w_sum     = r_mod + r_d2 + r_d1 + r_d0 + r_ctrl;
    assign w_to_term = (r_to_cnt == TO_W'(TO_LIMIT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // rx_done takes priority over the timeout terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        w_timeout   = 1'b0;
        if (bus.rx_done) begin
            case (r_state)
                ST_IDLE: if (bus.rx_data == HDR) w_state_nxt = ST_MOD;
                ST_MOD:  w_state_nxt = ST_D2;
                ST_D2:   w_state_nxt = ST_D1;
                ST_D1:   w_state_nxt = ST_D0;
                ST_D0:   w_state_nxt = ST_CTRL;
                ST_CTRL: w_state_nxt = ST_CHK;
                ST_CHK:  w_state_nxt = ST_TAIL;
                ST_TAIL: begin
                    w_state_nxt = ST_IDLE;
                    if (bus.rx_data == TAIL && w_sum == r_chk) w_good = 1'b1;
                    else                                       w_bad  = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && w_to_term) begin
            w_state_nxt = ST_IDLE;
            w_timeout   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE || bus.rx_done || w_to_term) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mod  <= '0;
            r_d2   <= '0;
            r_d1   <= '0;
            r_d0   <= '0;
            r_ctrl <= '0;
            r_chk  <= '0;
        end else if (bus.rx_done) begin
            case (r_state)
                ST_MOD:  r_mod  <= bus.rx_data;
                ST_D2:   r_d2   <= bus.rx_data;
                ST_D1:   r_d1   <= bus.rx_data;
                ST_D0:   r_d0   <= bus.rx_data;
                ST_CTRL: r_ctrl <= bus.rx_data;
                ST_CHK:  r_chk  <= bus.rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_d_out   <= '0;
            r_adr     <= '0;
            r_mod_sel <= '0;
            r_led     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= w_bad | w_timeout;
            if (w_good) begin
                r_d_out   <= {r_d2, r_d1, r_d0};
                r_adr     <= r_ctrl[CTRL_ADR_HI:CTRL_ADR_LO];
                r_mod_sel <= r_mod[5:0];
                r_led     <= ~r_led;
            end
        end
    end

    // Single-entry response slot; a newer response overwrites an unsent one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend    <= 1'b0;
            r_resp    <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_en <= 1'b0;
            if (r_pend && !bus.tx_busy) begin
                r_tx_en   <= 1'b1;
                r_tx_data <= r_resp;
                r_pend    <= 1'b0;
            end
            if (w_good || w_bad) begin
                r_pend <= 1'b1;
                r_resp <= w_good ? ACK : NAK;
            end
        end
    end

    assign w_trig = w_good & r_ctrl[CTRL_TRP_BIT];

    trp_pulse #(
        .TRP_WIDTH (TRP_WIDTH)
    ) u_trp_pulse (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .trig  (w_trig),
        .pulse (TRP)
    );

    assign D           = r_d_out;
    assign Adress      = r_adr;
    assign Mod_SEL     = r_mod_sel;
    assign led         = r_led;
    assign frame_err   = r_ferr;
    assign bus.tx_en   = r_tx_en;
    assign bus.tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Self-checking bench for uart_cmd_ctrl. Expected outputs come from a
// frame-level model (whole 8-byte frames judged by header/sum/tail).
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    localparam int unsigned P_CLK  = 50_000_000;
    localparam int unsigned P_BPS  = 115200;
    localparam int unsigned P_TOB  = 4;
    localparam int unsigned P_TRPW = 16;
    localparam int unsigned TO_CYC   = 32'(longint'(P_TOB) * 10 * longint'(P_CLK) / longint'(P_BPS));
    localparam int unsigned CHAR_CYC = 32'(10 * longint'(P_CLK) / longint'(P_BPS));

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        TRP, led, frame_err;

    always #5 sys_clk = ~sys_clk;

    uart_cmd_ctrl_if u_if();

    uart_cmd_ctrl #(
        .CLK_FREQ      (P_CLK),
        .UART_BPS      (P_BPS),
        .TIMEOUT_BYTES (P_TOB),
        .TRP_WIDTH     (P_TRPW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (u_if),
        .D         (D),
        .Adress    (Adress),
        .Mod_SEL   (Mod_SEL),
        .TRP       (TRP),
        .led       (led),
        .frame_err (frame_err)
    );

    int checks   = 0;
    int failures = 0;

    // Observed event streams
    logic [7:0] txq[$];
    int         trp_runs[$];
    int         trp_run  = 0;
    int         ferr_cnt = 0;

    always @(negedge sys_clk) begin
        if (u_if.tx_en === 1'b1) txq.push_back(u_if.tx_data);
        if (frame_err === 1'b1) ferr_cnt++;
        if (TRP === 1'b1) trp_run++;
        else if (trp_run != 0) begin
            trp_runs.push_back(trp_run);
            trp_run = 0;
        end
    end

    // Frame-level reference model
    logic [23:0] m_d;
    logic [1:0]  m_adr;
    logic [5:0]  m_mod;
    logic        m_led;

    function automatic logic [63:0] mk_frame(input logic [7:0] mod, input logic [23:0] d,
                                             input logic [7:0] ctrl);
        int s;
        s = int'(mod) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]) + int'(ctrl);
        return {8'hFF, mod, d, ctrl, 8'(s % 256), 8'h0A};
    endfunction

    function automatic bit frame_ok(input logic [63:0] f);
        int s;
        s = 0;
        for (int i = 1; i <= 5; i++) s = s + int'(f[63-8*i -: 8]);
        return (f[63:56] == 8'hFF) && (f[7:0] == 8'h0A) && (f[15:8] == 8'(s % 256));
    endfunction

    task automatic model_reset();
        m_d = '0; m_adr = '0; m_mod = '0; m_led = 1'b0;
    endtask

    task automatic model_frame(input logic [63:0] f, output bit good);
        good = frame_ok(f);
        if (good) begin
            m_d   = f[47:24];
            m_adr = f[17:16];
            m_mod = f[53:48];
            m_led = ~m_led;
        end
    endtask

    task automatic clear_mon();
        txq.delete();
        trp_runs.delete();
        ferr_cnt = 0;
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        u_if.rx_data = b;
        u_if.rx_done = 1'b1;
        @(posedge sys_clk);
        #1;
        u_if.rx_done = 1'b0;
        idle(gap);
    endtask

    task automatic send_frame(input logic [63:0] f, input int gap);
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], (i == 7) ? 0 : gap);
    endtask

    task automatic test_reset();
        sys_rst_n    = 1'b0;
        u_if.rx_done = 1'b0;
        u_if.rx_data = '0;
        u_if.tx_busy = 1'b0;
        model_reset();
        idle(3);
        checks++;
        if ({D, Adress, Mod_SEL, TRP, led, frame_err} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {D, Adress, Mod_SEL, TRP, led, frame_err});
        end
        checks++;
        if ({u_if.tx_en, u_if.tx_data} !== 9'd0) begin
            failures++;
            $display("FAIL reset_tx: got %h required 0", {u_if.tx_en, u_if.tx_data});
        end
        sys_rst_n = 1'b1;
        idle(2);
        clear_mon();
    endtask

    task automatic test_good_frame();
        logic [63:0] f;
        bit good;
        f = 64'hFF05_3F00_0F81_D40A;
        clear_mon();
        model_frame(f, good);
        send_frame(f, 1);
        checks++;
        if ({D, Adress, Mod_SEL, led} !== {24'h3F000F, 2'd1, 6'h05, m_led}) begin
            failures++;
            $display("FAIL good_apply: got %h/%h/%h/%b required 3f000f/1/05/%b", D, Adress, Mod_SEL, led, m_led);
        end
        checks++;
        if (TRP !== 1'b1 || u_if.tx_en !== 1'b0) begin
            failures++;
            $display("FAIL good_n1: TRP=%b tx_en=%b required TRP=1 tx_en=0", TRP, u_if.tx_en);
        end
        idle(1);
        checks++;
        if (u_if.tx_en !== 1'b1 || u_if.tx_data !== 8'h06) begin
            failures++;
            $display("FAIL good_n2_tx: tx_en=%b tx_data=%h required 1/06", u_if.tx_en, u_if.tx_data);
        end
        idle(30);
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h06 || ferr_cnt != 0) begin
            failures++;
            $display("FAIL good_resp: tx count=%0d ferr=%0d required 1 ACK and 0 ferr", txq.size(), ferr_cnt);
        end
        checks++;
        if (trp_runs.size() != 1 || trp_runs[0] != int'(P_TRPW)) begin
            failures++;
            $display("FAIL good_trp: pulses=%0d first=%0d required 1 of %0d", trp_runs.size(),
                     (trp_runs.size() > 0) ? trp_runs[0] : -1, P_TRPW);
        end
    endtask

    task automatic test_bad_checksum();
        logic [63:0] f;
        bit good;
        f = 64'hFF05_3F00_0F81_D50A;
        clear_mon();
        model_frame(f, good);
        send_frame(f, 1);
        checks++;
        if (frame_err !== 1'b1 || {D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL badchk_n1: ferr=%b out=%h required 1/%h", frame_err,
                     {D, Adress, Mod_SEL, led}, {m_d, m_adr, m_mod, m_led});
        end
        idle(30);
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h15 || ferr_cnt != 1 || trp_runs.size() != 0) begin
            failures++;
            $display("FAIL badchk_resp: tx=%0d ferr=%0d trp=%0d required 1 NAK, 1 ferr, 0 trp",
                     txq.size(), ferr_cnt, trp_runs.size());
        end
    endtask

    task automatic test_timeout();
        logic [63:0] f;
        bit good;
        int k;
        f = 64'hFF05_3F00_0F81_D40A;
        clear_mon();
        for (int i = 0; i < 7; i++) send_byte(f[63-8*i -: 8], (i == 6) ? 0 : 1);
        k = 0;
        while (frame_err !== 1'b1 && k < int'(TO_CYC) + 100) begin
            idle(1);
            k++;
        end
        checks++;
        if (k < int'(TO_CYC) - 1 || k > int'(TO_CYC) + 1) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", k, TO_CYC);
        end
        idle(6 * int'(CHAR_CYC) - k);
        checks++;
        if (ferr_cnt != 1 || txq.size() != 0 || {D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL timeout_effect: ferr=%0d tx=%0d out=%h required 1/0/%h", ferr_cnt, txq.size(),
                     {D, Adress, Mod_SEL, led}, {m_d, m_adr, m_mod, m_led});
        end
        f = mk_frame(8'h05, 24'h3F000F, 8'h02);
        clear_mon();
        model_frame(f, good);
        send_frame(f, 1);
        checks++;
        if (Adress !== 2'd2 || {D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL after_timeout_apply: got %h required %h", {D, Adress, Mod_SEL, led},
                     {m_d, m_adr, m_mod, m_led});
        end
        idle(30);
        checks++;
        if (trp_runs.size() != 0 || txq.size() != 1 || txq[0] !== 8'h06) begin
            failures++;
            $display("FAIL after_timeout_resp: trp=%0d tx=%0d required 0 trp, 1 ACK", trp_runs.size(), txq.size());
        end
        // Inter-byte gap landing exactly on the terminal count must not time out.
        f = mk_frame(8'h2C, 24'h0A0B0C, 8'h01);
        clear_mon();
        model_frame(f, good);
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], (i == 3) ? int'(TO_CYC) - 1 : ((i == 7) ? 0 : 1));
        idle(30);
        checks++;
        if (ferr_cnt != 0 || txq.size() != 1 || txq[0] !== 8'h06 ||
            {D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL gap_at_limit: ferr=%0d tx=%0d out=%h required 0/1/%h", ferr_cnt, txq.size(),
                     {D, Adress, Mod_SEL, led}, {m_d, m_adr, m_mod, m_led});
        end
    endtask

    task automatic test_junk();
        logic [63:0] f;
        bit good;
        f = mk_frame(8'h12, 24'hFF00FF, 8'h01);
        clear_mon();
        model_frame(f, good);
        send_byte(8'h00, 1);
        send_byte(8'hAA, 1);
        send_frame(f, 1);
        checks++;
        if (D !== 24'hFF00FF || {D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL junk_apply: got %h required %h", {D, Adress, Mod_SEL, led}, {m_d, m_adr, m_mod, m_led});
        end
        idle(30);
        checks++;
        if (ferr_cnt != 0 || txq.size() != 1 || txq[0] !== 8'h06) begin
            failures++;
            $display("FAIL junk_resp: ferr=%0d tx=%0d required 0/1 ACK", ferr_cnt, txq.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f1, f2;
        bit good;
        f1 = mk_frame(8'h21, 24'h123456, 8'h80);
        f2 = mk_frame(8'h3A, 24'hABCDEF, 8'h83);
        clear_mon();
        u_if.tx_busy = 1'b1;
        model_frame(f1, good);
        model_frame(f2, good);
        send_frame(f1, 0);
        send_frame(f2, 0);
        checks++;
        if ({D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led}) begin
            failures++;
            $display("FAIL b2b_apply: got %h required %h", {D, Adress, Mod_SEL, led}, {m_d, m_adr, m_mod, m_led});
        end
        idle(40);
        checks++;
        if (txq.size() != 0) begin
            failures++;
            $display("FAIL b2b_busy_hold: tx=%0d required 0", txq.size());
        end
        // Second trigger lands 8 cycles into the first pulse.
        checks++;
        if (trp_runs.size() != 1 || trp_runs[0] != 8 + int'(P_TRPW)) begin
            failures++;
            $display("FAIL b2b_trp: pulses=%0d first=%0d required 1 of %0d", trp_runs.size(),
                     (trp_runs.size() > 0) ? trp_runs[0] : -1, 8 + P_TRPW);
        end
        u_if.tx_busy = 1'b0;
        idle(10);
        checks++;
        if (txq.size() != 1 || txq[0] !== 8'h06) begin
            failures++;
            $display("FAIL b2b_release: tx=%0d required 1 ACK", txq.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] f;
        bit good;
        f = mk_frame(8'h07, 24'h010203, 8'h80);
        model_frame(f, good);
        send_frame(f, 0);
        for (int i = 0; i < 4; i++) send_byte(f[63-8*i -: 8], 0);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({D, Adress, Mod_SEL, TRP, led, frame_err, u_if.tx_en} !== 36'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h required 0", {D, Adress, Mod_SEL, TRP, led, frame_err, u_if.tx_en});
        end
        idle(2);
        sys_rst_n = 1'b1;
        idle(2);
        clear_mon();
        f = mk_frame(8'h09, 24'h00C0DE, 8'h03);
        model_frame(f, good);
        send_frame(f, 1);
        idle(30);
        checks++;
        if ({D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led} || txq.size() != 1 ||
            txq[0] !== 8'h06 || ferr_cnt != 0) begin
            failures++;
            $display("FAIL midreset_next: out=%h tx=%0d ferr=%0d required %h/1/0", {D, Adress, Mod_SEL, led},
                     txq.size(), ferr_cnt, {m_d, m_adr, m_mod, m_led});
        end
    endtask

    task automatic test_random();
        logic [63:0] f;
        logic [7:0]  mod, ctrl, t;
        logic [23:0] d;
        bit          good, trig;
        int          kind;
        for (int it = 0; it < 24; it++) begin
            mod  = 8'($urandom);
            d    = 24'($urandom);
            ctrl = 8'($urandom);
            f    = mk_frame(mod, d, ctrl);
            kind = int'($urandom_range(0, 3));
            if (kind == 1) f[15:8] = f[15:8] ^ 8'(1 << $urandom_range(0, 7));
            if (kind == 2) begin
                t = 8'($urandom);
                f[7:0] = (t == 8'h0A) ? 8'h0B : t;
            end
            clear_mon();
            model_frame(f, good);
            trig = good && f[23];
            if (kind == 3) begin
                t = 8'($urandom);
                send_byte((t == 8'hFF) ? 8'h55 : t, 1);
            end
            send_frame(f, int'($urandom_range(0, 2)));
            checks++;
            if ({D, Adress, Mod_SEL, led} !== {m_d, m_adr, m_mod, m_led} || frame_err !== !good) begin
                failures++;
                $display("FAIL rand_apply[%0d]: out=%h ferr=%b required %h/%b", it, {D, Adress, Mod_SEL, led},
                         frame_err, {m_d, m_adr, m_mod, m_led}, !good);
            end
            idle(int'(P_TRPW) + 8);
            checks++;
            if (txq.size() != 1 || txq[0] !== (good ? 8'h06 : 8'h15) || ferr_cnt != (good ? 0 : 1)) begin
                failures++;
                $display("FAIL rand_resp[%0d]: tx=%0d byte=%h ferr=%0d required 1/%h/%0d", it, txq.size(),
                         (txq.size() > 0) ? txq[0] : 8'hXX, ferr_cnt, good ? 8'h06 : 8'h15, good ? 0 : 1);
            end
            checks++;
            if (trp_runs.size() != (trig ? 1 : 0) || (trig && trp_runs[0] != int'(P_TRPW))) begin
                failures++;
                $display("FAIL rand_trp[%0d]: pulses=%0d required %0d of %0d", it, trp_runs.size(),
                         trig ? 1 : 0, P_TRPW);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_junk();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
